uart_register_top: RTL and testbench
====================================

# uart_register_top

APB-slave UART peripheral: a 32-bit APB register interface in front of an 8N1 transmitter and receiver with small TX/RX FIFOs. The CPU pushes bytes for transmission and pops received bytes through memory-mapped registers. The block sits on the peripheral bus and drives/receives the serial pins directly. The bit rate is a fixed integer division of the bus clock, 9600 baud at 100 MHz by default.

## Interface
- CLK_DIV, 10416: bus-clock cycles per serial bit.
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs (power of two).
- pClk  in  1  bus clock, single clock domain, rising edge.
- pReset  in  1  reset, asynchronous and active-low.
- pSel  in  1  APB select.
- pEnable  in  1  APB access phase.
- pWrite  in  1  1 = write, 0 = read.
- pAddr  in  32  register address. Only pAddr[1:0] is decoded, as a register index.
- pWdata  in  32  write data. Only valid in the access phase.
- RxD  in  1  serial input, asynchronous, idle high.
- TxD  out  1  serial output, idle high.
- pReadData  out  32  read data.

## Operation
- Register index 0, TXDATA (W): a write pushes pWdata[7:0] into the TX FIFO. A write to a full FIFO is dropped and sets TXOVF. Reads return 0.
- Register index 1, RXDATA (R): a read returns the head of the RX FIFO in [7:0] and pops it. Reading an empty FIFO returns 0 and does not pop. Writes are ignored.
- Register index 2, STATUS (R, W1C on bits 5..7). Bits:
  - bit0 TXEMPTY, bit1 TXFULL, bit2 RXEMPTY, bit3 RXFULL, bit4 TXBUSY (frame in progress).
  - bit5 TXOVF, bit6 RXOVR (byte received while RX FIFO full; byte lost), bit7 FERR (stop bit sampled 0).
  - Writing 1 to bits 5..7 clears them.
- Register index 3, CTRL (R/W): bit0 TXEN, bit1 RXEN. Other bits read 0.
- Transmitter:
  - When idle, TXEN=1 and the TX FIFO is not empty, pop one byte and send a frame: start bit 0, data bits 0..7 LSB first, stop bit 1.
  - Repeat back-to-back while TXEN=1 and the FIFO is not empty.
  - Clearing TXEN mid-frame lets the current frame finish, then transmission stops. The FIFO contents are retained.
- Receiver (active only while RXEN=1):
  - RxD passes through a 2-flop synchronizer.
  - IDLE: a falling edge moves to START.
  - START: resample at CLK_DIV/2. If the line is high, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits, each CLK_DIV cycles apart at bit centre, LSB first.
  - STOP: sample the stop bit. If it is 1, push the byte to the RX FIFO, or set RXOVR if the FIFO is full. If it is 0, set FERR and discard the byte.
  - Then return to IDLE.
  - Clearing RXEN aborts reception to IDLE. Bytes already in the FIFO are kept.
- Reset values:
  - TxD=1, pReadData=0.
  - CTRL=0, FIFOs empty, status error flags 0.
  - Both state machines in IDLE.

## Timing
- APB:
  - Setup phase: pSel=1, pEnable=0. Access phase: pSel=1, pEnable=1. The slave has no wait states.
  - Writes take effect at the rising edge where pSel&pEnable&pWrite.
  - pReadData is combinational while pSel&!pWrite and is 0 otherwise.
  - The RXDATA pop happens once per transfer, at the access-phase edge.
- A TXDATA write and a TX pop in the same cycle are both honoured, including when the FIFO is full.
- An RX push and an RXDATA pop in the same cycle are both honoured, including when the FIFO is full.
- TxD start-bit latency: the start bit appears within 2 pClk cycles of the TXEN/FIFO-not-empty condition.
- Frame length:
  - Each bit is held for exactly CLK_DIV cycles.
  - A frame is 10*CLK_DIV cycles.
  - The next frame starts with no idle gap.
- TXBUSY is high from start-bit drive until the end of the stop bit.
- RX sample points: 2 synchronizer cycles + CLK_DIV/2 + n*CLK_DIV after the falling edge, for n = 1..8 (data bits) and n = 9 (stop bit).
- An RX byte is visible in RXDATA/STATUS one cycle after the stop-bit sample.
- Asserting reset mid-frame immediately returns TxD to 1 and clears all state.

## Test plan
- Reset (pReset pulse low) -> TxD=1, STATUS read = 0x05, CTRL read = 0.
- Write TXDATA 10, 15, 7 with TXEN=0, then write CTRL=1:
  - TxD carries frames 0x0A, 0x0F, 0x07, back-to-back, 10416 cycles per bit, LSB first.
  - TXEMPTY=1 after the third frame.
- Write 5 bytes with TXEN=0 -> the 5th byte is dropped, TXOVF=1, TXFULL=1. Writing 0x20 to STATUS clears TXOVF.
- With CTRL=2, drive RxD frames 0x14, 0x0A, 0x07 at 104160 ns per bit -> three RXDATA reads return 0x14, 0x0A, 0x07, then RXEMPTY=1.
- Drive 5 frames without reading -> RXFULL=1 and RXOVR=1; the first 4 bytes are preserved.
- Drive a frame with stop bit 0 -> FERR=1, RX FIFO unchanged.
- Drive a start pulse shorter than CLK_DIV/2 -> no byte, no error.

Source files
------------

// File: rtl/uart_register_top.sv
// uart_register_top: APB-slave UART with 8N1 transmitter/receiver and small TX/RX FIFOs.
//
// State machines:
//   state    | meaning
//   TX_IDLE  | line idle high, waiting for TXEN and a queued byte
//   TX_SEND  | shifting out start, 8 data bits (LSB first) and stop bit
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | waiting half a bit to confirm the start bit
//   RX_DATA  | sampling 8 data bits at bit centres
//   RX_STOP  | sampling the stop bit, then push byte or flag an error
//
// Ports:
//   pClk, pReset            bus clock, async active-low reset
//   pSel/pEnable/pWrite     APB control (no wait states)
//   pAddr[1:0]              register index: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL
//   pWdata, pReadData       APB data
//   RxD, TxD                serial pins, idle high
module uart_register_top #(
  parameter int CLK_DIV    = 10416,
  parameter int FIFO_DEPTH = 4          // power of two, at least 2
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pSel,
  input  logic        pEnable,
  input  logic        pWrite,
  input  logic [31:0] pAddr,
  input  logic [31:0] pWdata,
  input  logic        RxD,
  output logic        TxD,
  output logic [31:0] pReadData
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);

  typedef enum logic       {TX_IDLE, TX_SEND} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  logic          unusedBits;
  assign unusedBits = ^{pAddr[31:2], pWdata[31:8]};

  // APB decode
  logic [1:0] regIdx;
  logic       wrEn, rdAcc;
  assign regIdx = pAddr[1:0];
  assign wrEn   = pSel & pEnable & pWrite;
  assign rdAcc  = pSel & pEnable & ~pWrite;

  logic txEn, rxEn, txOvf, rxOvr, fErr;

  // FIFO storage
  logic [7:0]    txMem [FIFO_DEPTH];
  logic [7:0]    rxMem [FIFO_DEPTH];
  logic [AW-1:0] txWp, txRp, rxWp, rxRp;
  logic [CW-1:0] txCnt, rxCnt;
  logic          txEmpty, txFull, rxEmpty, rxFull;
  logic          txPush, txPop, rxPush, rxPop;

  assign txEmpty = (txCnt == '0);
  assign txFull  = (txCnt == CW'(FIFO_DEPTH));
  assign rxEmpty = (rxCnt == '0);
  assign rxFull  = (rxCnt == CW'(FIFO_DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign txPush = wrEn && (regIdx == 2'd0) && (!txFull || txPop);
  assign rxPop  = rdAcc && (regIdx == 2'd1) && !rxEmpty;

  // Transmitter
  txState_t      txState, txStateNext;
  logic [TW-1:0] txTimer;
  logic [3:0]    txBitCnt;
  logic [8:0]    txShift;
  logic          txLoad, txShiftEn, txBusy;

  assign txBusy = (txState == TX_SEND);

  always_comb begin
    txStateNext = txState;
    txPop       = 1'b0;
    txLoad      = 1'b0;
    txShiftEn   = 1'b0;
    case (txState)
      TX_IDLE: if (txEn && !txEmpty) begin
        txPop       = 1'b1;
        txLoad      = 1'b1;
        txStateNext = TX_SEND;
      end
      TX_SEND: if (txTimer == '0) begin
        if (txBitCnt != 4'd0) txShiftEn = 1'b1;
        else if (txEn && !txEmpty) begin
          txPop  = 1'b1;
          txLoad = 1'b1;
        end else txStateNext = TX_IDLE;
      end
      default: txStateNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) txState <= TX_IDLE;
    else         txState <= txStateNext;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      TxD      <= 1'b1;
      txShift  <= '1;
      txBitCnt <= '0;
      txTimer  <= '0;
    end else if (txLoad) begin
      TxD      <= 1'b0;
      txShift  <= {1'b1, txMem[txRp]};
      txBitCnt <= 4'd9;
      txTimer  <= BIT_LAST;
    end else if (txShiftEn) begin
      TxD      <= txShift[0];
      txShift  <= {1'b1, txShift[8:1]};
      txBitCnt <= txBitCnt - 4'd1;
      txTimer  <= BIT_LAST;
    end else if (txBusy && txTimer != '0) begin
      txTimer  <= txTimer - 1'b1;
    end
  end

  // Receiver
  rxState_t      rxState, rxStateNext;
  logic          rxS1, rxSync, rxPrev, rxFall;
  logic [TW-1:0] rxTimer;
  logic [2:0]    rxBitCnt;
  logic [7:0]    rxShift;
  logic          rxLoadHalf, rxLoadBit, rxSample, rxStopSample;
  logic          rxPushReq, rxOvrSet, fErrSet;

  assign rxFall = rxPrev & ~rxSync;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxS1   <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxS1   <= RxD;
      rxSync <= rxS1;
      rxPrev <= rxSync;
    end
  end

  always_comb begin
    rxStateNext  = rxState;
    rxLoadHalf   = 1'b0;
    rxLoadBit    = 1'b0;
    rxSample     = 1'b0;
    rxStopSample = 1'b0;
    if (!rxEn) rxStateNext = RX_IDLE;
    else begin
      case (rxState)
        RX_IDLE: if (rxFall) begin
          rxStateNext = RX_START;
          rxLoadHalf  = 1'b1;
        end
        RX_START: if (rxTimer == '0) begin
          if (rxSync) rxStateNext = RX_IDLE;   // start bit vanished: glitch
          else begin
            rxStateNext = RX_DATA;
            rxLoadBit   = 1'b1;
          end
        end
        RX_DATA: if (rxTimer == '0) begin
          rxSample  = 1'b1;
          rxLoadBit = 1'b1;
          if (rxBitCnt == 3'd7) rxStateNext = RX_STOP;
        end
        RX_STOP: if (rxTimer == '0) begin
          rxStopSample = 1'b1;
          rxStateNext  = RX_IDLE;
        end
        default: rxStateNext = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) rxState <= RX_IDLE;
    else         rxState <= rxStateNext;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxTimer  <= '0;
      rxBitCnt <= '0;
      rxShift  <= '0;
    end else begin
      if (rxLoadHalf)          rxTimer <= HALF_LAST;
      else if (rxLoadBit)      rxTimer <= BIT_LAST;
      else if (rxTimer != '0)  rxTimer <= rxTimer - 1'b1;
      if (rxState == RX_IDLE)  rxBitCnt <= '0;
      else if (rxSample)       rxBitCnt <= rxBitCnt + 3'd1;
      if (rxSample)            rxShift <= {rxSync, rxShift[7:1]};
    end
  end

  assign rxPushReq = rxStopSample & rxSync;
  assign fErrSet   = rxStopSample & ~rxSync;
  assign rxPush    = rxPushReq & (~rxFull | rxPop);
  assign rxOvrSet  = rxPushReq & rxFull & ~rxPop;

  // FIFO pointers and storage
  always_ff @(posedge pClk) begin
    if (txPush) txMem[txWp] <= pWdata[7:0];
    if (rxPush) rxMem[rxWp] <= rxShift;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      txWp <= '0; txRp <= '0; txCnt <= '0;
      rxWp <= '0; rxRp <= '0; rxCnt <= '0;
    end else begin
      if (txPush) txWp <= txWp + 1'b1;
      if (txPop)  txRp <= txRp + 1'b1;
      if (txPush && !txPop)      txCnt <= txCnt + CW'(1);
      else if (!txPush && txPop) txCnt <= txCnt - CW'(1);
      if (rxPush) rxWp <= rxWp + 1'b1;
      if (rxPop)  rxRp <= rxRp + 1'b1;
      if (rxPush && !rxPop)      rxCnt <= rxCnt + CW'(1);
      else if (!rxPush && rxPop) rxCnt <= rxCnt - CW'(1);
    end
  end

  // Control and sticky flags; a new event wins over a same-cycle clear.
  logic stWr;
  assign stWr = wrEn && (regIdx == 2'd2);

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      txEn <= 1'b0; rxEn <= 1'b0;
      txOvf <= 1'b0; rxOvr <= 1'b0; fErr <= 1'b0;
    end else begin
      if (wrEn && regIdx == 2'd3) begin
        txEn <= pWdata[0];
        rxEn <= pWdata[1];
      end
      if (wrEn && regIdx == 2'd0 && txFull && !txPop) txOvf <= 1'b1;
      else if (stWr && pWdata[5])                     txOvf <= 1'b0;
      if (rxOvrSet)                 rxOvr <= 1'b1;
      else if (stWr && pWdata[6])   rxOvr <= 1'b0;
      if (fErrSet)                  fErr <= 1'b1;
      else if (stWr && pWdata[7])   fErr <= 1'b0;
    end
  end

  logic [7:0] status;
  assign status = {fErr, rxOvr, txOvf, txBusy, rxFull, rxEmpty, txFull, txEmpty};

  always_comb begin
    pReadData = '0;
    if (pSel && !pWrite) begin
      case (regIdx)
        2'd1: if (!rxEmpty) pReadData = {24'd0, rxMem[rxRp]};
        2'd2: pReadData = {24'd0, status};
        2'd3: pReadData = {30'd0, rxEn, txEn};
        default: pReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_register_top.sv
module tb_uart_register_top;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic        pClk = 1'b0;
  logic        pReset = 1'b0;
  logic        pSel = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
  logic [31:0] pAddr = '0, pWdata = '0;
  logic        RxD = 1'b1;
  logic        TxD;
  logic [31:0] pReadData;

  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;

  uart_register_top #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata), .RxD(RxD), .TxD(TxD), .pReadData(pReadData)
  );

  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc++;

  // Serial line monitor: decodes frames seen on TxD at bit centres.
  logic [7:0] txGot[$];
  int         txStart[$];
  logic       txStop[$];

  initial begin
    int         s;
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge pClk);
      if (pReset && TxD === 1'b0) begin
        s = cyc;
        repeat (DIV/2) @(negedge pClk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge pClk);
          b[i] = TxD;
        end
        repeat (DIV) @(negedge pClk);
        stp = TxD;
        txGot.push_back(b);
        txStart.push_back(s);
        txStop.push_back(stp);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected STATUS from the model's view of the block.
  function automatic logic [31:0] expStatus(input int txN, input int rxN, input bit busy,
                                            input bit txovf, input bit rxovr, input bit ferr);
    logic [31:0] v;
    v = 0;
    if (txN == 0)     v = v + 1;
    if (txN == DEPTH) v = v + 2;
    if (rxN == 0)     v = v + 4;
    if (rxN == DEPTH) v = v + 8;
    if (busy)         v = v + 16;
    if (txovf)        v = v + 32;
    if (rxovr)        v = v + 64;
    if (ferr)         v = v + 128;
    return v;
  endfunction

  task automatic apbWrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge pClk);
    pSel = 1'b1; pWrite = 1'b1; pEnable = 1'b0; pAddr = {30'd0, a}; pWdata = d;
    @(negedge pClk);
    pEnable = 1'b1;
    @(negedge pClk);
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
  endtask

  task automatic apbRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge pClk);
    pSel = 1'b1; pWrite = 1'b0; pEnable = 1'b0; pAddr = {30'd0, a};
    @(negedge pClk);
    pEnable = 1'b1;
    #1 d = pReadData;
    @(negedge pClk);
    pSel = 1'b0; pEnable = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    @(negedge pClk);
    RxD = 1'b0;
    repeat (DIV) @(negedge pClk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (DIV) @(negedge pClk);
    end
    RxD = stopBit;
    repeat (DIV) @(negedge pClk);
    RxD = 1'b1;
    repeat (4) @(negedge pClk);
  endtask

  task automatic waitTx(input int n);
    int k;
    k = 0;
    while (txGot.size() < n && k < 12 * DIV * (n + 1)) begin
      @(negedge pClk);
      k++;
    end
    check("tx_frame_count", txGot.size(), n);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  q[$];
    logic [7:0]  rb;
    int          ctrlCyc;

    // Reset
    pReset = 1'b0;
    repeat (3) @(negedge pClk);
    #1 check("reset_txd", {31'd0, TxD}, 1);
    pReset = 1'b1;
    check("idle_rdata", pReadData, 0);
    apbRead(2'd2, rd); check("reset_status", rd, expStatus(0, 0, 0, 0, 0, 0));
    apbRead(2'd3, rd); check("reset_ctrl", rd, 0);
    apbRead(2'd1, rd); check("empty_rxdata", rd, 0);
    apbRead(2'd0, rd); check("txdata_read", rd, 0);

    // Three queued frames, released by TXEN
    apbWrite(2'd0, 32'h0A); apbWrite(2'd0, 32'h0F); apbWrite(2'd0, 32'h07);
    apbRead(2'd2, rd); check("tx_queued_status", rd, expStatus(3, 0, 0, 0, 0, 0));
    txGot.delete(); txStart.delete(); txStop.delete();
    apbWrite(2'd3, 32'h1);
    ctrlCyc = cyc;
    repeat (4) @(negedge pClk);
    apbRead(2'd2, rd); check("tx_busy_status", rd, expStatus(2, 0, 1, 0, 0, 0));
    waitTx(3);
    if (txGot.size() == 3) begin
      check("tx_byte0", txGot[0], 8'h0A);
      check("tx_byte1", txGot[1], 8'h0F);
      check("tx_byte2", txGot[2], 8'h07);
      check("tx_stop_bits", {29'd0, txStop[0], txStop[1], txStop[2]}, 7);
      check("tx_start_latency", {31'd0, (txStart[0] - ctrlCyc) <= 2}, 1);
      check("tx_gap01", txStart[1] - txStart[0], 10 * DIV);
      check("tx_gap12", txStart[2] - txStart[1], 10 * DIV);
    end
    repeat (DIV) @(negedge pClk);
    apbRead(2'd2, rd); check("tx_done_status", rd, expStatus(0, 0, 0, 0, 0, 0));

    // TX overflow with random bytes
    apbWrite(2'd3, 32'h0);
    q.delete();
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom);
      if (q.size() < DEPTH) q.push_back(rb);
      apbWrite(2'd0, {24'd0, rb});
    end
    apbRead(2'd2, rd); check("txovf_status", rd, expStatus(DEPTH, 0, 0, 1, 0, 0));
    apbWrite(2'd2, 32'h20);
    apbRead(2'd2, rd); check("txovf_clear", rd, expStatus(DEPTH, 0, 0, 0, 0, 0));
    txGot.delete(); txStart.delete(); txStop.delete();
    apbWrite(2'd3, 32'h1);
    waitTx(DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (i < txGot.size()) check("tx_rand_byte", txGot[i], q[i]);
    repeat (DIV) @(negedge pClk);
    apbWrite(2'd3, 32'h0);

    // Clearing TXEN mid-frame finishes that frame and keeps the rest queued
    apbWrite(2'd0, 32'hC3); apbWrite(2'd0, 32'h5A);
    txGot.delete(); txStart.delete(); txStop.delete();
    apbWrite(2'd3, 32'h1);
    apbWrite(2'd3, 32'h0);
    waitTx(1);
    repeat (25 * DIV) @(negedge pClk);
    check("txen_off_frames", txGot.size(), 1);
    apbRead(2'd2, rd); check("txen_off_status", rd, expStatus(1, 0, 0, 0, 0, 0));
    apbWrite(2'd3, 32'h1);
    waitTx(2);
    if (txGot.size() == 2) begin
      check("txen_off_b0", txGot[0], 8'hC3);
      check("txen_off_b1", txGot[1], 8'h5A);
    end
    repeat (DIV) @(negedge pClk);

    // Receive three directed bytes
    apbWrite(2'd3, 32'h2);
    q.delete();
    q.push_back(8'h14); q.push_back(8'h0A); q.push_back(8'h07);
    for (int i = 0; i < 3; i++) sendRx(q[i], 1'b1);
    for (int i = 0; i < 3; i++) begin
      apbRead(2'd1, rd); check("rx_byte", rd, {24'd0, q[i]});
    end
    apbRead(2'd2, rd); check("rx_empty_status", rd, expStatus(0, 0, 0, 0, 0, 0));

    // RX overflow with random bytes
    q.delete();
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom);
      if (q.size() < DEPTH) q.push_back(rb);
      sendRx(rb, 1'b1);
    end
    apbRead(2'd2, rd); check("rxovr_status", rd, expStatus(0, DEPTH, 0, 0, 1, 0));
    for (int i = 0; i < DEPTH; i++) begin
      apbRead(2'd1, rd); check("rx_rand_byte", rd, {24'd0, q[i]});
    end
    apbRead(2'd2, rd); check("rxovr_after_read", rd, expStatus(0, 0, 0, 0, 1, 0));
    apbWrite(2'd2, 32'h40);
    apbRead(2'd2, rd); check("rxovr_clear", rd, expStatus(0, 0, 0, 0, 0, 0));

    // Framing error leaves the FIFO untouched
    rb = 8'($urandom);
    sendRx(rb, 1'b1);
    sendRx(8'($urandom), 1'b0);
    apbRead(2'd2, rd); check("ferr_status", rd, expStatus(0, 1, 0, 0, 0, 1));
    apbRead(2'd1, rd); check("ferr_keep_byte", rd, {24'd0, rb});
    apbWrite(2'd2, 32'h80);
    apbRead(2'd2, rd); check("ferr_clear", rd, expStatus(0, 0, 0, 0, 0, 0));

    // Short start pulse is a glitch
    @(negedge pClk);
    RxD = 1'b0;
    repeat (DIV/4) @(negedge pClk);
    RxD = 1'b1;
    repeat (12 * DIV) @(negedge pClk);
    apbRead(2'd2, rd); check("glitch_status", rd, expStatus(0, 0, 0, 0, 0, 0));
    apbRead(2'd1, rd); check("glitch_rxdata", rd, 0);

    // Reset mid-frame
    apbWrite(2'd3, 32'h1);
    apbWrite(2'd0, 32'h00);
    repeat (2 * DIV) @(negedge pClk);
    check("midframe_txd_low", {31'd0, TxD}, 0);
    pReset = 1'b0;
    #1 check("midframe_reset_txd", {31'd0, TxD}, 1);
    repeat (2) @(negedge pClk);
    pReset = 1'b1;
    apbRead(2'd3, rd); check("midframe_reset_ctrl", rd, 0);
    apbRead(2'd2, rd); check("midframe_reset_status", rd, expStatus(0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
